// File: rtl/debug_memory_dump_requester.sv
// Debug memory dump requester.
// Walks data memory from word 0 to N_WORDS-1. For each word it selects the
// memory debug controller, waits for the returned frame, and then streams
// the frame MSB-byte-first to the debug UART TX over valid/ready.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for i_start; select parked on IDLE_SELECT
// REQUEST  | one cycle: raise select to CONTROLLER_ID, clear timeout count
// WAIT     | select held; wait for i_writing or abort on timeout
// SEND     | stream captured frame bytes over the valid/ready handshake
// FINISH   | one cycle: pulse done, release busy, rewind address
module debug_memory_dump_requester #(
    parameter int          NB_CONTROL_FRAME = 32,
    parameter int          NB_ADDR          = 10,
    parameter int          N_WORDS          = 1024,
    parameter logic [5:0]  CONTROLLER_ID    = 6'b0000_00,
    parameter logic [5:0]  IDLE_SELECT      = 6'b1111_11,
    parameter int          TIMEOUT_CYCLES   = 15
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_start,
    input  logic                        i_writing,
    input  logic [NB_CONTROL_FRAME-1:0] i_frame_from_controller,
    input  logic                        i_tx_ready,
    output logic [5:0]                  o_request_select,
    output logic [NB_ADDR-1:0]          o_mem_addr,
    output logic [7:0]                  o_tx_data,
    output logic                        o_tx_valid,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_error
);

    localparam int NB_BYTES = NB_CONTROL_FRAME / 8;
    localparam int NB_BCNT  = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

    localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(NB_BYTES - 1);
    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(N_WORDS - 1);
    localparam logic [7:0]         TMO_LAST  = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQUEST,
        ST_WAIT,
        ST_SEND,
        ST_FINISH
    } state_t;

    state_t                      state_q,    state_d;
    logic [5:0]                  select_q,   select_d;
    logic [NB_ADDR-1:0]          addr_q,     addr_d;
    logic [7:0]                  tx_data_q,  tx_data_d;
    logic                        tx_valid_q, tx_valid_d;
    logic                        busy_q,     busy_d;
    logic                        done_q,     done_d;
    logic                        error_q,    error_d;
    logic [NB_CONTROL_FRAME-1:0] shift_q,    shift_d;
    logic [7:0]                  tmo_cnt_q,  tmo_cnt_d;
    logic [NB_BCNT-1:0]          byte_cnt_q, byte_cnt_d;

    // Frame with the byte just transferred dropped; its top byte is the next one out.
    logic [NB_CONTROL_FRAME-1:0] shift_next;
    assign shift_next = shift_q << 8;

    // State and every output register; reset aborts any dump in flight.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            select_q   <= IDLE_SELECT;
            addr_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            shift_q    <= '0;
            tmo_cnt_q  <= '0;
            byte_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            select_q   <= select_d;
            addr_q     <= addr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            shift_q    <= shift_d;
            tmo_cnt_q  <= tmo_cnt_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    // Next-state and next-output decode; done/error are single-cycle pulses.
    always_comb begin
        state_d    = state_q;
        select_d   = select_q;
        addr_d     = addr_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        shift_d    = shift_q;
        tmo_cnt_d  = tmo_cnt_q;
        byte_cnt_d = byte_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    state_d = ST_REQUEST;
                end
            end

            ST_REQUEST: begin
                // The rising match on select is what triggers the controller's read.
                select_d  = CONTROLLER_ID;
                tmo_cnt_d = '0;
                state_d   = ST_WAIT;
            end

            ST_WAIT: begin
                if (i_writing) begin
                    // First byte is presented together with the capture so that
                    // o_tx_data/o_tx_valid come straight from registers.
                    shift_d    = i_frame_from_controller;
                    tx_data_d  = i_frame_from_controller[NB_CONTROL_FRAME-1 -: 8];
                    tx_valid_d = 1'b1;
                    select_d   = IDLE_SELECT;
                    byte_cnt_d = '0;
                    state_d    = ST_SEND;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    select_d  = IDLE_SELECT;
                    error_d   = 1'b1;
                    busy_d    = 1'b0;
                    addr_d    = '0;
                    tmo_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end

            ST_SEND: begin
                if (tx_valid_q && i_tx_ready) begin
                    if (byte_cnt_q == LAST_BYTE) begin
                        tx_valid_d = 1'b0;
                        if (addr_q == LAST_ADDR) begin
                            state_d = ST_FINISH;
                        end else begin
                            addr_d  = addr_q + NB_ADDR'(1);
                            state_d = ST_REQUEST;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + NB_BCNT'(1);
                        shift_d    = shift_next;
                        tx_data_d  = shift_next[NB_CONTROL_FRAME-1 -: 8];
                    end
                end
            end

            ST_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                addr_d  = '0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_request_select = select_q;
    assign o_mem_addr       = addr_q;
    assign o_tx_data        = tx_data_q;
    assign o_tx_valid       = tx_valid_q;
    assign o_busy           = busy_q;
    assign o_done           = done_q;
    assign o_error          = error_q;

endmodule
